// File: rtl/conv_result_sink.sv
// Output sink for the 3x3 convolution engine: drops incomplete-window border
// samples, requantizes kept sums to 8 bits and queues them on a valid/ready stream.
module conv_result_sink #(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned SUM_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [SUM_WIDTH-1:0] in_sum,
  input  logic [4:0]           shift,
  input  logic                 signed_out,
  input  logic                 ovf_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;

  localparam logic signed [SUM_WIDTH-1:0] S_P127 = SUM_WIDTH'(127);
  localparam logic signed [SUM_WIDTH-1:0] S_N128 = SUM_WIDTH'(-128);
  localparam logic signed [SUM_WIDTH-1:0] S_P255 = SUM_WIDTH'(255);
  localparam logic signed [SUM_WIDTH-1:0] S_ZERO = '0;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last_c, row_last_c, keep_c;

  logic signed [SUM_WIDTH-1:0] shifted_c;
  logic [7:0]                  quant_c;
  logic                        q_valid;
  logic [7:0]                  q_data;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next_c;
  logic [NW-1:0] count, count_next_c;
  logic          full_c, pop_c, push_c, drop_c;
  logic [7:0]    head_next_c;

  assign col_last_c = (col == CW'(IMG_WIDTH - 1));
  assign row_last_c = (row == RW'(IMG_HEIGHT - 1));
  assign keep_c     = (col >= CW'(2)) && (row >= RW'(2));

  // Frame position; advances only on accepted input samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_valid && col_last_c && row_last_c;
      if (in_valid) begin
        if (col_last_c) begin
          col <= '0;
          row <= row_last_c ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign shifted_c = $signed(in_sum) >>> shift;

  // Saturate the shifted sum into the selected 8-bit range
  always_comb begin
    quant_c = shifted_c[7:0];
    if (signed_out) begin
      if (shifted_c > S_P127)      quant_c = 8'h7f;
      else if (shifted_c < S_N128) quant_c = 8'h80;
    end else begin
      if (shifted_c < S_ZERO)      quant_c = 8'h00;
      else if (shifted_c > S_P255) quant_c = 8'hff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      q_valid <= in_valid && keep_c;
      if (in_valid && keep_c) q_data <= quant_c;
    end
  end

  assign full_c       = (count == NW'(FIFO_DEPTH));
  assign pop_c        = out_valid && out_ready;
  assign push_c       = q_valid && (!full_c || pop_c);
  assign drop_c       = q_valid && full_c && !pop_c;
  assign rd_next_c    = pop_c ? rd_ptr + AW'(1) : rd_ptr;
  assign count_next_c = count + NW'(push_c) - NW'(pop_c);
  // A write landing on the next head slot only happens when the FIFO runs dry
  assign head_next_c  = (push_c && (wr_ptr == rd_next_c)) ? q_data : mem[rd_next_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= q_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_next_c;
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
      out_data  <= head_next_c;
      if (drop_c)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_result_sink.sv
// Randomized and directed bench for conv_result_sink against a queue-based frame model.
module tb_conv_result_sink;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int DEPTH = 4;
  localparam int NPIX  = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_sum;
  logic [4:0]  shift;
  logic        signed_out;
  logic        ovf_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        frame_done;
  logic        overflow;

  conv_result_sink #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
    .shift(shift), .signed_out(signed_out), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending outputs plus one-sample requantize latency
  logic [7:0] q[$];
  bit         m_ovf, m_fd, st_v;
  logic [7:0] st_d;
  int         idx;
  logic [7:0] popped[$];
  int         expq[$];
  int         fd_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit keep(input int p);
    return ((p % W) >= 2) && ((p / W) >= 2);
  endfunction

  function automatic logic [7:0] quant(input logic [31:0] s, input logic [4:0] sh, input logic sg);
    longint t;
    t = longint'($signed(s)) >>> sh;
    if (sg) begin
      if (t > 127) t = 127;
      if (t < -128) t = -128;
    end else begin
      if (t > 255) t = 255;
      if (t < 0) t = 0;
    end
    return 8'(t);
  endfunction

  // Check registered outputs, then advance the model across one clock edge
  task automatic cycle();
    bit pop, drop;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (out_valid && out_ready) popped.push_back(out_data);
    if (frame_done) fd_seen++;
    pop  = (q.size() != 0) && out_ready;
    drop = st_v && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (st_v && !drop) q.push_back(st_d);
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_fd = in_valid && (idx == NPIX - 1);
    st_v = in_valid && keep(idx);
    st_d = quant(in_sum, shift, signed_out);
    if (in_valid) idx = (idx + 1) % NPIX;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] s);
    in_valid = v;
    in_sum   = s;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_fd  = 1'b0;
    st_v  = 1'b0;
    idx   = 0;
  endtask

  task automatic cmp_popped(input string tag);
    chk({tag, "_count"}, 32'(popped.size()), 32'(expq.size()));
    for (int i = 0; i < popped.size() && i < expq.size(); i++)
      chk(tag, 32'(popped[i]), 32'(expq[i]));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; shift = '0;
    signed_out = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Ramp frame: only the interior window positions survive
    popped.delete(); fd_seen = 0;
    for (int k = 0; k < NPIX; k++) drive(1'b1, 32'(k));
    idle(4);
    expq = {12, 13, 14, 17, 18, 19};
    cmp_popped("ramp");
    chk("ramp_frame_done_cnt", 32'(fd_seen), 32'd1);

    // Saturation on kept positions, unsigned then signed
    for (int pass = 0; pass < 2; pass++) begin
      shift = 5'd4; signed_out = pass[0];
      popped.delete();
      begin
        int s;
        s = 0;
        for (int k = 0; k < NPIX; k++) begin
          if (keep(k)) begin
            case (s % 3)
              0: drive(1'b1, 32'h0000_1000);
              1: drive(1'b1, 32'hFFFF_FFE0);
              default: drive(1'b1, 32'h0000_0FF0);
            endcase
            s++;
          end else begin
            drive(1'b1, $urandom);
          end
        end
      end
      idle(4);
      if (pass == 0) expq = {255, 0, 255, 255, 0, 255};
      else expq = {127, 254, 127, 127, 254, 127};
      cmp_popped(pass == 0 ? "sat_u" : "sat_s");
    end

    // Backpressure: fill, drop, clear overflow, then drain in order
    shift = 5'd0; signed_out = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < NPIX; k++) drive(1'b1, 32'(k + 100));
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_overflow", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    for (int k = 0; k < NPIX; k++) drive(1'b1, 32'(k + 150));
    idle(2);
    chk("bp_ovf_cleared", 32'(overflow), 32'h0);
    ovf_clr = 1'b0;
    popped.delete();
    out_ready = 1'b1;
    idle(8);
    expq = {112, 113, 114, 117};
    cmp_popped("bp_drain");

    // Full FIFO with simultaneous push and pop keeps streaming losslessly
    popped.delete();
    out_ready = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      if (k == 19) out_ready = 1'b1;
      drive(1'b1, 32'(k + 40));
    end
    for (int k = 0; k < NPIX; k++) drive(1'b1, 32'(k + 60));
    idle(8);
    expq = {52, 53, 54, 57, 58, 59, 72, 73, 74, 77, 78, 79};
    cmp_popped("full_pp");
    chk("full_pp_overflow", 32'(overflow), 32'h0);

    // Reset mid-row with a loaded FIFO, then a clean frame
    out_ready = 1'b0;
    for (int k = 0; k < 19; k++) drive(1'b1, 32'(k + 7));
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    do_reset();
    out_ready = 1'b1;
    popped.delete();
    for (int k = 0; k < NPIX; k++) drive(1'b1, 32'(k + 30));
    idle(4);
    expq = {42, 43, 44, 47, 48, 49};
    cmp_popped("post_rst");

    // Random traffic, geometry/format changes only at frame boundaries
    for (int n = 0; n < 1500; n++) begin
      if (idx == 0 && !in_valid) begin
        shift      = 5'($urandom_range(0, 20));
        signed_out = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0) || (n % 200 > 150);
      if (n % 200 < 40) out_ready = 1'b0;
      ovf_clr   = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      if (idx == 0 && $urandom_range(0, 3) == 0) in_valid = 1'b0;
      in_sum    = ($urandom_range(0, 1) == 1) ? $urandom
                : 32'($signed($urandom_range(0, 16383)) - 8192);
      cycle();
    end
    ovf_clr = 1'b0; out_ready = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
